// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter in front of a single FIFO, with a flush sequencer.
// Optional per-requester grant counters are enabled by FIFO_PUSH_ARBITER_STATS_EN.
//
// state   | meaning
// IDLE    | normal operation, round-robin grants allowed
// DRAIN   | grants stopped, waiting for FIFO empty or timeout
// FLUSH   | one-cycle FIFO flush pulse, rr pointer and stats cleared
// RECOVER | one quiet cycle, then done (and timeout) pulse
module fifo_push_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int DRAIN_ON_FLUSH = 1,
  parameter int TIMEOUT        = 64,
  parameter int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          flush_req_i,
  output logic                          flush_busy_o,
  output logic                          flush_done_o,
  output logic                          flush_timeout_o,
  input  logic                          fifo_full_i,
  input  logic                          fifo_empty_i,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          fifo_flush_o,
  output logic [NUM_REQ*16-1:0]         grant_cnt_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    FLUSH   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_flag_q, tmo_flag_d;

  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] win_next;
  logic             grant_en;
  logic             grant;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  assign win_next = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  // Reset gating keeps every output low while rst_i is held.
  assign grant_en = !rst_i && (state_q == IDLE) && !flush_req_i && !fifo_full_i;
  assign grant    = grant_en && found;

  always_comb begin
    req_ready_o = '0;
    fifo_push_o = 1'b0;
    fifo_data_o = '0;
    if (grant) begin
      req_ready_o[win] = 1'b1;
      fifo_push_o      = 1'b1;
      fifo_data_o      = req_data_i[win*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    tmo_cnt_d       = tmo_cnt_q;
    tmo_flag_d      = tmo_flag_q;
    flush_busy_o    = 1'b0;
    fifo_flush_o    = 1'b0;
    flush_done_o    = 1'b0;
    flush_timeout_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) rr_ptr_d = win_next;
        if (flush_req_i && !rst_i) state_d = (DRAIN_ON_FLUSH != 0) ? DRAIN : FLUSH;
      end
      DRAIN: begin
        flush_busy_o = 1'b1;
        // Empty wins over timeout when both hold in the same cycle.
        if (fifo_empty_i) begin
          state_d = FLUSH;
        end else if (tmo_cnt_q >= CNT_W'(TIMEOUT - 1)) begin
          state_d    = FLUSH;
          tmo_flag_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        flush_busy_o = 1'b1;
        fifo_flush_o = 1'b1;
        rr_ptr_d     = '0;
        state_d      = RECOVER;
      end
      RECOVER: begin
        flush_busy_o    = 1'b1;
        flush_done_o    = 1'b1;
        flush_timeout_o = tmo_flag_q;
        tmo_flag_d      = 1'b0;
        tmo_cnt_d       = '0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FIFO_PUSH_ARBITER_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [15:0] cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else if (state_q == FLUSH) begin
        cnt_q <= '0;
      end else if (grant && (win == IDX_W'(i)) && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign grant_cnt_o[i*16 +: 16] = cnt_q;
  end
`else
  assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: round-robin order, full back-pressure,
// drain/timeout flush sequencing, reset abort and (when enabled) grant stats.
module tb_fifo_push_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int TIMEOUT    = 8;

  logic                          clk_i = 1'b0;
  logic                          rst_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          flush_req_i;
  logic                          flush_busy_o;
  logic                          flush_done_o;
  logic                          flush_timeout_o;
  logic                          fifo_full_i;
  logic                          fifo_empty_i;
  logic                          fifo_push_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic                          fifo_flush_o;
  logic [NUM_REQ*16-1:0]         grant_cnt_o;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  fifo_push_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DRAIN_ON_FLUSH(1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .flush_req_i(flush_req_i), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
    .flush_timeout_o(flush_timeout_o), .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
    .fifo_push_o(fifo_push_o), .fifo_data_o(fifo_data_o), .fifo_flush_o(fifo_flush_o),
    .grant_cnt_o(grant_cnt_o)
  );

  // Payload of requester i is 32'hD0D0_00i0.
  assign req_data_i = {32'hD0D0_0030, 32'hD0D0_0020, 32'hD0D0_0010, 32'hD0D0_0000};

  task automatic test_reset();
    rst_i = 1'b1; req_valid_i = 4'hF; flush_req_i = 1'b0;
    fifo_full_i = 1'b0; fifo_empty_i = 1'b0;
    @(negedge clk_i); @(negedge clk_i); #1;
    vectors++;
    if (req_ready_o !== 4'b0 || fifo_push_o !== 1'b0 || fifo_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_grant: ready=%b push=%b data=%h, required 0/0/0", req_ready_o, fifo_push_o, fifo_data_o);
    end
    vectors++;
    if (flush_busy_o !== 1'b0 || flush_done_o !== 1'b0 || fifo_flush_o !== 1'b0 || grant_cnt_o !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_flush: busy=%b done=%b flush=%b cnt=%h, required all 0", flush_busy_o, flush_done_o, fifo_flush_o, grant_cnt_o);
    end
    req_valid_i = 4'h0;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic expect_grant(input string name, input int w);
    logic [NUM_REQ-1:0] er;
    logic [31:0]        ed;
    er = '0;
    ed = '0;
    if (w >= 0) begin
      er[w] = 1'b1;
      ed = 32'hD0D0_0000 | (w << 4);
    end
    #1;
    vectors++;
    if (req_ready_o !== er || fifo_push_o !== (w >= 0) || fifo_data_o !== ed) begin
      miscompares++;
      $display("FAIL %s: ready=%b push=%b data=%h, required ready=%b push=%b data=%h",
               name, req_ready_o, fifo_push_o, fifo_data_o, er, (w >= 0), ed);
    end
    @(negedge clk_i);
  endtask

  task automatic test_round_robin();
    req_valid_i = 4'hF;
    for (int c = 0; c < 8; c++) expect_grant("rr_all_valid", c % 4);
    req_valid_i = 4'h0;
    expect_grant("rr_none_valid", -1);
  endtask

  task automatic test_rr_wrap();
    req_valid_i = 4'b0010;
    expect_grant("wrap_setup", 1);
    req_valid_i = 4'b0011;
    expect_grant("wrap_from2", 0);
    expect_grant("wrap_ptr1", 1);
  endtask

  task automatic test_full();
    req_valid_i = 4'b1000;
    fifo_full_i = 1'b1;
    for (int c = 0; c < 3; c++) expect_grant("full_blocked", -1);
    fifo_full_i = 1'b0;
    expect_grant("full_released", 3);
    req_valid_i = 4'h0;
  endtask

  task automatic test_flush_drain();
    req_valid_i = 4'b0010;
    expect_grant("drain_setup", 1);
    req_valid_i = 4'hF;
    flush_req_i = 1'b1;
    expect_grant("drain_req_cycle", -1);
    flush_req_i = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      fifo_empty_i = (c >= 5);
      #1;
      vectors++;
      if (flush_busy_o !== 1'b1 || fifo_flush_o !== (c == 6) || flush_done_o !== (c == 7) ||
          flush_timeout_o !== 1'b0 || req_ready_o !== 4'b0) begin
        miscompares++;
        $display("FAIL drain_seq c%0d: busy=%b flush=%b done=%b tmo=%b ready=%b, required 1/%b/%b/0/0000",
                 c, flush_busy_o, fifo_flush_o, flush_done_o, flush_timeout_o, req_ready_o, (c == 6), (c == 7));
      end
      @(negedge clk_i);
    end
    #1;
    vectors++;
    if (flush_busy_o !== 1'b0 || flush_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_end: busy=%b done=%b, required 0/0", flush_busy_o, flush_done_o);
    end
    expect_grant("drain_rr_reset", 0);
    req_valid_i = 4'h0;
    fifo_empty_i = 1'b0;
  endtask

  task automatic test_flush_timeout();
    fifo_empty_i = 1'b0;
    flush_req_i = 1'b1;
    @(negedge clk_i);
    flush_req_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      flush_req_i = (c == 3);
      #1;
      vectors++;
      if (flush_busy_o !== (c <= 10) || fifo_flush_o !== (c == 9) ||
          flush_done_o !== (c == 10) || flush_timeout_o !== (c == 10)) begin
        miscompares++;
        $display("FAIL timeout_seq c%0d: busy=%b flush=%b done=%b tmo=%b, required %b/%b/%b/%b",
                 c, flush_busy_o, fifo_flush_o, flush_done_o, flush_timeout_o,
                 (c <= 10), (c == 9), (c == 10), (c == 10));
      end
      @(negedge clk_i);
    end
    flush_req_i = 1'b0;
  endtask

  task automatic test_flush_empty_first();
    fifo_empty_i = 1'b1;
    flush_req_i = 1'b1;
    @(negedge clk_i);
    flush_req_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      vectors++;
      if (flush_busy_o !== (c <= 3) || fifo_flush_o !== (c == 2) ||
          flush_done_o !== (c == 3) || flush_timeout_o !== 1'b0) begin
        miscompares++;
        $display("FAIL empty_first c%0d: busy=%b flush=%b done=%b tmo=%b, required %b/%b/%b/0",
                 c, flush_busy_o, fifo_flush_o, flush_done_o, flush_timeout_o, (c <= 3), (c == 2), (c == 3));
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_stats();
    logic [15:0] e1;
    req_valid_i = 4'b0010;
    for (int c = 0; c < 3; c++) expect_grant("stats_grant", 1);
    req_valid_i = 4'h0;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    e1 = 16'd3;
`else
    e1 = 16'd0;
`endif
    fifo_empty_i = 1'b1;
    flush_req_i = 1'b1;
    #1;
    vectors++;
    if (grant_cnt_o[31:16] !== e1 || grant_cnt_o[15:0] !== 16'd0) begin
      miscompares++;
      $display("FAIL stats_count: cnt1=%0d cnt0=%0d, required %0d/0", grant_cnt_o[31:16], grant_cnt_o[15:0], e1);
    end
    @(negedge clk_i);
    flush_req_i = 1'b0;
    @(negedge clk_i);
    #1;
    vectors++;
    if (fifo_flush_o !== 1'b1 || grant_cnt_o[31:16] !== e1) begin
      miscompares++;
      $display("FAIL stats_at_flush: flush=%b cnt1=%0d, required 1/%0d", fifo_flush_o, grant_cnt_o[31:16], e1);
    end
    @(negedge clk_i);
    #1;
    vectors++;
    if (grant_cnt_o !== 64'h0) begin
      miscompares++;
      $display("FAIL stats_cleared: cnt=%h, required 0", grant_cnt_o);
    end
    @(negedge clk_i);
    fifo_empty_i = 1'b0;
  endtask

  task automatic test_reset_abort();
    flush_req_i = 1'b1;
    @(negedge clk_i);
    flush_req_i = 1'b0;
    #1;
    vectors++;
    if (flush_busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy: busy=%b, required 1", flush_busy_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    vectors++;
    if (flush_busy_o !== 1'b0 || flush_done_o !== 1'b0 || fifo_flush_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset: busy=%b done=%b flush=%b, required 0/0/0", flush_busy_o, flush_done_o, fifo_flush_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (flush_busy_o !== 1'b0 || flush_done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_no_done: busy=%b done=%b, required 0/0", flush_busy_o, flush_done_o);
      end
      @(negedge clk_i);
    end
    req_valid_i = 4'b0100;
    expect_grant("abort_resume", 2);
    req_valid_i = 4'h0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_rr_wrap();
    test_full();
    test_flush_drain();
    test_flush_timeout();
    test_flush_empty_first();
    test_stats();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares the push side of one fifo_v3 instance among NUM_REQ producers using round-robin arbitration.
- Sequences queue flushes: stop granting, optionally drain until empty (with timeout), pulse the FIFO flush, then resume.
- Sits between producer valid/ready ports and the FIFO's push_i/data_i/flush_i/full_o/empty_o.

Parameters:
- NUM_REQ, 4, number of producers (>=2).
- DATA_WIDTH, 32, payload width.
- DRAIN_ON_FLUSH, 1, 1 = wait for FIFO empty before flushing; 0 = flush immediately.
- TIMEOUT, 64, maximum DRAIN cycles before a forced flush (>=1).
- IDX_W, $clog2(NUM_REQ), derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  NUM_REQ  producer valid, one bit per requester
- req_data_i  in  NUM_REQ*DATA_WIDTH  producer payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready_o  out  NUM_REQ  one-hot grant/accept
- flush_req_i  in  1  flush request pulse
- flush_busy_o  out  1  flush sequence in progress
- flush_done_o  out  1  one-cycle pulse when the sequence completes
- flush_timeout_o  out  1  one-cycle pulse with flush_done_o if DRAIN timed out
- fifo_full_i  in  1  FIFO full_o
- fifo_empty_i  in  1  FIFO empty_o
- fifo_push_o  out  1  FIFO push_i
- fifo_data_o  out  DATA_WIDTH  FIFO data_i
- fifo_flush_o  out  1  FIFO flush_i
- grant_cnt_o  out  NUM_REQ*16  per-requester grant counts (see Optional Feature)

Behaviour:
- Reset: state=IDLE, rr_ptr=0, timeout counter=0. All outputs 0 while reset is asserted. Reset mid-sequence aborts it with no done pulse.
- Arbitration is combinational within a cycle:
  - Grants are enabled only when state==IDLE, flush_req_i==0 and fifo_full_i==0.
  - The winner is the first valid requester at or after rr_ptr, scanning upward with wrap from NUM_REQ-1 to 0.
- On a grant:
  - req_ready_o[w]=1.
  - fifo_push_o=1.
  - fifo_data_o = slice w of req_data_i.
  - On the next edge, rr_ptr <= (w+1) mod NUM_REQ.
- With no grant, rr_ptr holds, req_ready_o=0, fifo_push_o=0 and fifo_data_o=0.
- Zero-latency transfer: a handshake on cycle N is a FIFO push on cycle N. Valid is not required to be held, and no payload is stored internally.
- FIFO full: no grants are issued and rr_ptr holds, so the pending winner is served first once space frees.
- Flush FSM:
  - IDLE: flush_req_i=1 goes to DRAIN if DRAIN_ON_FLUSH=1, else to FLUSH. Grants are suppressed in the request cycle.
  - DRAIN: no grants; timeout counter increments each cycle.
    - Go to FLUSH when fifo_empty_i=1 or the counter reaches TIMEOUT-1.
    - On timeout exit, latch a timeout flag.
    - Empty on the first DRAIN cycle takes precedence over timeout.
  - FLUSH: fifo_flush_o=1 for exactly one cycle, then go to RECOVER.
  - RECOVER: one cycle with no grants. Then go to IDLE with flush_done_o=1 and flush_timeout_o = latched flag; clear the flag and counter.
  - flush_busy_o=1 in DRAIN, FLUSH and RECOVER.
  - flush_req_i outside IDLE is ignored (not queued).
- rr_ptr resets to 0 on the FLUSH cycle.
- Timeout counter width is $clog2(TIMEOUT+1). It does not wrap.

Optional Feature:
- Macro FIFO_PUSH_ARBITER_STATS_EN.
- Defined:
  - grant_cnt_o slice i is a 16-bit counter incremented on each grant to requester i.
  - Saturates at 16'hFFFF.
  - Cleared by reset and on the FLUSH cycle.
- Undefined: grant_cnt_o is tied to 0 and no counter flops exist.

Test Plan:
- All 4 valid continuously, FIFO never full, 8 cycles -> grants 0,1,2,3,0,1,2,3; fifo_data_o matches each winner's slice.
- rr_ptr=2, valid=4'b0011 -> grant to 0, then rr_ptr=1 next cycle -> grant to 1.
- fifo_full_i=1 for 3 cycles with valid=4'b1000 -> no push for 3 cycles; req 3 is granted on the first cycle after full drops.
- DRAIN_ON_FLUSH=1; flush_req_i pulse with FIFO non-empty; fifo_empty_i rises 5 cycles later -> busy=1 for 5+2 cycles, fifo_flush_o one cycle, done=1, timeout=0.
- TIMEOUT=4; flush_req_i with fifo_empty_i stuck 0 -> FLUSH after 4 DRAIN cycles; done=1 and timeout=1 together; a second flush_req_i during DRAIN is ignored.
- Stats enabled: 3 grants to req 1, then flush -> grant_cnt_o[31:16]=3 before FLUSH, 0 after; counter preloaded to 16'hFFFF stays 16'hFFFF on further grants.
